// File: rtl/pdm_cic_decimator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pdm_cic_decimator_if                                            |
// | Purpose  : PDM input, enable and PCM valid/ready bundle for the decimator  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface pdm_cic_decimator_if #(
  parameter int DECIM_LOG2 = 6
);
  localparam int W = 2*DECIM_LOG2 + 1;

  logic         ena;
  logic         pdm_in;
  logic [W-1:0] pcm_data;
  logic         pcm_valid;
  logic         pcm_ready;
  logic         overrun;
  logic         overrun_clr;

  // master: the decimator, which sources the PCM stream
  modport master (
    input  ena, pdm_in, pcm_ready, overrun_clr,
    output pcm_data, pcm_valid, overrun
  );

  modport slave (
    output ena, pdm_in, pcm_ready, overrun_clr,
    input  pcm_data, pcm_valid, overrun
  );
endinterface
`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pdm_cic_decimator                                               |
// | Purpose  : 2nd-order CIC, PDM bitstream to PCM, 1-entry valid/ready buffer |
// | Options  : PDM_DECIM_SYNC_EN - 2-flop synchronizer on pdm_in and ena       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pdm_cic_decimator #(
  parameter int DECIM_LOG2 = 6
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pdm_cic_decimator_if.master bus
);
  localparam int W = 2*DECIM_LOG2 + 1;

  localparam logic [1:0] ST_PRIME0 = 2'd0;
  localparam logic [1:0] ST_PRIME1 = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic w_bit;
  logic w_ena;

`ifdef PDM_DECIM_SYNC_EN
  // ena travels with the data so frame boundaries stay aligned to the same bits
  logic [1:0] sync_bit_q;
  logic [1:0] sync_ena_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_bit_q <= '0;
      sync_ena_q <= '0;
    end else begin
      sync_bit_q <= {sync_bit_q[0], bus.pdm_in};
      sync_ena_q <= {sync_ena_q[0], bus.ena};
    end
  end

  assign w_bit = sync_bit_q[1];
  assign w_ena = sync_ena_q[1];
`else
  assign w_bit = bus.pdm_in;
  assign w_ena = bus.ena;
`endif

  logic [W-1:0]          i1_q, i1_d;
  logic [W-1:0]          i2_q, i2_d;
  logic [W-1:0]          i2_dly_q;
  logic [W-1:0]          c1_dly_q;
  logic [W-1:0]          w_c1;
  logic [W-1:0]          w_y;
  logic [W-1:0]          y_q;
  logic                  y_vld_q;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                  w_dec;
  logic [1:0]            state_q, state_d;
  logic                  w_run;
  logic [W-1:0]          pcm_data_q, pcm_data_d;
  logic                  pcm_valid_q, pcm_valid_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    cnt_d = cnt_q;
    if (w_ena) begin
      i1_d  = i1_q + {{(W-1){1'b0}}, w_bit};
      i2_d  = i2_q + i1_d;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The comb sees the integrator value that already includes this instant's bit
  assign w_dec = w_ena && (cnt_q == '1);
  assign w_c1  = i2_d - i2_dly_q;
  assign w_y   = w_c1 - c1_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PRIME0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_dec) begin
      case (state_q)
        ST_PRIME0: state_d = ST_PRIME1;
        ST_PRIME1: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_run = (state_q == ST_RUN);
  end

  always_comb begin
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = pcm_valid_q;
    overrun_d   = overrun_q;
    if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (y_vld_q) begin
      if (!pcm_valid_q || bus.pcm_ready) begin
        pcm_data_d  = y_q;
        pcm_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.pcm_ready) begin
      pcm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q        <= '0;
      i2_q        <= '0;
      i2_dly_q    <= '0;
      c1_dly_q    <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      y_vld_q     <= 1'b0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      cnt_q   <= cnt_d;
      y_vld_q <= w_dec && w_run;
      if (w_dec) begin
        i2_dly_q <= i2_d;
        c1_dly_q <= w_c1;
        y_q      <= w_y;
      end
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.pcm_data  = pcm_data_q;
  assign bus.pcm_valid = pcm_valid_q;
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pdm_cic_decimator                                            |
// | Purpose  : directed and random stimulus against a triangular-FIR model      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pdm_cic_decimator;
  localparam int DL = 6;
  localparam int R  = 1 << DL;
`ifdef PDM_DECIM_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif
  localparam int FIRST = 3*R + 1 + SLAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pdm_cic_decimator_if #(.DECIM_LOG2(DL)) bus ();
  pdm_cic_decimator #(.DECIM_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int total = 0;
  int bad   = 0;
  int mode  = 1;
  int ph    = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PDM pattern source: 0 zeros, 1 ones, 2 alternating, 3 one-in-four, else random
  initial begin
    bus.pdm_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (mode)
        0:       bus.pdm_in = 1'b0;
        1:       bus.pdm_in = 1'b1;
        2:       bus.pdm_in = (ph % 2 == 0);
        3:       bus.pdm_in = (ph % 4 == 0);
        default: bus.pdm_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference: each sample is the last 2R-1 enabled bits weighted by a triangle
  bit          hist[$];
  bit          m_init = 1'b0;
  bit          m_valid, m_ov, m_ovset, pend, m_b, m_e;
  bit          sb1, sb2, se1, se2;
  int unsigned m_data, pend_y;

  function automatic int unsigned cic_out(input int n);
    int unsigned s = 0;
    for (int j = 0; j < 2*R-1; j++) begin
      if (n-1-j >= 0 && hist[n-1-j]) s += (j < R) ? j+1 : 2*R-1-j;
    end
    return s;
  endfunction

  always begin
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_valid = 0; m_ov = 0; m_data = 0; pend = 0;
      sb1 = 0; sb2 = 0; se1 = 0; se2 = 0;
      m_init = 1;
    end else begin
`ifdef PDM_DECIM_SYNC_EN
      m_b = sb2; m_e = se2;
      sb2 = sb1; sb1 = bus.pdm_in;
      se2 = se1; se1 = bus.ena;
`else
      m_b = bus.pdm_in; m_e = bus.ena;
`endif
      m_ovset = 0;
      if (pend) begin
        if (!m_valid || bus.pcm_ready) begin
          m_data = pend_y; m_valid = 1;
        end else begin
          m_ovset = 1;
        end
      end else if (bus.pcm_ready) begin
        m_valid = 0;
      end
      if (m_ovset) m_ov = 1;
      else if (bus.overrun_clr) m_ov = 0;
      pend = 0;
      if (m_e) begin
        hist.push_back(m_b);
        if (hist.size() % R == 0 && hist.size() >= 3*R) begin
          pend = 1;
          pend_y = cic_out(hist.size());
        end
      end
    end
    @(negedge clk);
    if (m_init) begin
      check("pcm_valid", bus.pcm_valid, m_valid);
      check("pcm_data", bus.pcm_data, m_data);
      check("overrun", bus.overrun, m_ov);
    end
  end

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.pcm_valid) begin
        n = i;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_valid: no pcm_valid within %0d cycles", budget);
  endtask

  task automatic expect_samples(input int skip, input int cnt, input int unsigned val, input string name);
    int n;
    repeat (skip) wait_valid(3*R, n);
    repeat (cnt) begin
      wait_valid(3*R, n);
      check(name, bus.pcm_data, val);
    end
  endtask

  initial begin
    int n;
    bus.ena = 1'b1;
    bus.pcm_ready = 1'b1;
    bus.overrun_clr = 1'b0;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_valid", bus.pcm_valid, 0);
    check("rst_data", bus.pcm_data, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b0;

    wait_valid(4*R, n);
    check("first_valid_cycle", n, FIRST);
    check("ones_first", bus.pcm_data, 4096);
    wait_valid(3*R, n);
    check("spacing", n, R);
    check("ones", bus.pcm_data, 4096);

    mode = 0; expect_samples(3, 2, 0, "zeros");
    mode = 2; expect_samples(3, 2, 2048, "alternating");
    mode = 3; expect_samples(3, 2, 1024, "quarter");
    mode = 1; expect_samples(3, 1, 4096, "ones_again");

    // Hold ready low across the next instant
    bus.pcm_ready = 1'b0;
    repeat (R + 2) @(posedge clk);
    #1;
    check("ovr_set", bus.overrun, 1);
    check("ovr_valid_held", bus.pcm_valid, 1);
    check("ovr_data_held", bus.pcm_data, 4096);
    bus.overrun_clr = 1'b1;
    @(posedge clk); #1;
    bus.overrun_clr = 1'b0;
    check("ovr_clear", bus.overrun, 0);
    bus.pcm_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_falls", bus.pcm_valid, 0);

    // Enable gap mid-frame stretches the spacing by the gap length
    wait_valid(3*R, n);
    repeat (20) @(posedge clk);
    #1;
    bus.ena = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    bus.ena = 1'b1;
    wait_valid(3*R, n);
    check("ena_gap_spacing", n + 120, R + 100);
    check("ena_gap_value", bus.pcm_data, 4096);

    // Single-cycle reset mid-stream
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", bus.pcm_valid, 0);
    check("midrst_data", bus.pcm_data, 0);
    check("midrst_overrun", bus.overrun, 0);
    rst = 1'b0;
    wait_valid(4*R, n);
    check("midrst_first", n, FIRST);
    check("midrst_value", bus.pcm_data, 4096);

    // Random traffic, checked cycle by cycle against the model
    mode = 4;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      bus.ena         = ($urandom_range(0, 7) != 0);
      bus.pcm_ready   = ($urandom_range(0, 3) != 0);
      bus.overrun_clr = ($urandom_range(0, 15) == 0);
      rst             = (i == 3000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Receive-side companion to the chip's 1-bit PDM audio output: converts the PDM bitstream on `uo_out[0]` back into PCM samples. Uses a 2nd-order CIC decimator with power-of-two ratio and a one-entry valid/ready output buffer. Sits in the bench and FPGA capture path next to the SID top level, and runs on the same 5 MHz clock.

## Interface
- `DECIM_LOG2`, default 6 — log2 of the decimation ratio R. R = 64 gives a 78.125 kHz output rate at 5 MHz.
- `W` — derived localparam, W = 2·DECIM_LOG2+1 (13 at default). Not overridable.
- `clk`  in  1 — single clock, rising edge.
- `rst`  in  1 — synchronous, active-high reset.
- `ena`  in  1 — input sample enable. While low, the integrators, decimation counter and warm-up counter hold their values.
- `pdm_in`  in  1 — PDM bit, 1 = +full-scale, 0 = zero.
- `pcm_data`  out  W — unsigned PCM sample, range 0..2^(2·DECIM_LOG2).
- `pcm_valid`  out  1 — `pcm_data` holds an unconsumed sample.
- `pcm_ready`  in  1 — consumer accepts the sample this cycle.
- `overrun`  out  1 — sticky flag: a sample was dropped.
- `overrun_clr`  in  1 — clears `overrun`.

## Operation
- Reset clears all of the following to 0: integrators i1, i2; comb delays; decimation counter cnt; warm-up counter; `pcm_data`, `pcm_valid`, `overrun`.
- Integrators run on every cycle with `ena`=1: i1 ← i1 + x, then i2 ← i2 + i1 (new i1). Both are W bits and wrap modulo 2^W; the wrap is intentional and harmless.
- Decimation counter cnt runs 0..R-1 and advances on `ena`. The cycle with cnt = R-1 and `ena`=1 is the decimation instant.
- At each decimation instant, the combs compute c1 = i2 − i2_d and y = c1 − c1_d, both modulo 2^W. They then update i2_d ← i2 and c1_d ← c1.
- Warm-up: the first 2 decimation instants after reset only prime the comb delays. y is produced from the 3rd instant onward.
- Steady-state DC gain is R². All-ones input gives y = 4096, all-zeros gives y = 0, and an alternating 1010… input gives y = 2048 exactly (R = 64).
- Output buffer, evaluated in the cycle after a decimation instant produces y. Handshake rules:
  - `pcm_valid`=0: load y and set `pcm_valid`.
  - `pcm_valid`=1 and `pcm_ready`=1 in the same cycle: the old sample is consumed, y is loaded, and `pcm_valid` stays 1.
  - `pcm_valid`=1 and `pcm_ready`=0: y is dropped, `pcm_data` keeps the old sample, and `overrun` is set.
  - `pcm_ready`=1 with no new y: `pcm_valid` clears next cycle.
- `overrun_clr` and a new overrun in the same cycle: the set wins.
- `ena` low mid-frame: the frame resumes where it stopped, and the output buffer and handshake keep operating.
- `rst` mid-frame: everything returns to reset state and warm-up restarts.

## Timing
- An input bit presented in cycle t is captured into i1 at edge t+1 (+2 with the synchronizer).
- The decimation instant is at edge e. `pcm_valid` and `pcm_data` change at edge e+1, giving 1 cycle of latency from the last contributing bit's integrator update.
- The first `pcm_valid` occurs 3R+1 enabled cycles after reset release (193 at R = 64), +2 with the synchronizer.
- Valid samples are spaced exactly R enabled cycles apart.
- `pcm_valid` never drops without a `pcm_ready` handshake.

## Configuration
- `PDM_DECIM_SYNC_EN` defined: `pdm_in` passes through a 2-flop synchronizer (reset to 0) before the integrators. All input-to-output latencies grow by 2 cycles, and the decimation phase is unchanged.
- Not defined: `pdm_in` feeds i1 directly. The source must be synchronous to `clk`.

## Test plan
- Reset with `rst`=1 for 10 cycles → `pcm_valid`=0, `pcm_data`=0, `overrun`=0. First `pcm_valid` at cycle 193 after release (195 with the macro).
- `pdm_in`=1 constant, `pcm_ready`=1 → every sample after warm-up = 4096. `pdm_in`=0 → 0.
- Alternating 1010… pattern → every post-warm-up sample = 2048. A 25% pattern (1000…) → 1024.
- `pcm_ready`=0 across two decimation instants → `pcm_data` holds the first sample and `overrun`=1. Then pulse `overrun_clr` → `overrun`=0; pulse `pcm_ready` → `pcm_valid` falls next cycle.
- `ena` low for 100 cycles mid-frame with constant-1 input → sample spacing extends by 100 cycles and values stay 4096.
- Assert `rst` for 1 cycle mid-stream → all outputs 0 next cycle and the first new sample arrives 193 cycles after release.
